mips_register_file: RTL and testbench

- 32 x 32-bit general-purpose register file for the 32-bit MIPS datapath.
- It is the storage and read end of the register-write path:
  - writeback drives the single write port;
  - decode reads two operands through registered read ports.
- Register $0 is hardwired to zero.
- Same-cycle write-to-read forwarding is built in, so decode never sees stale data.

---
 rtl/mips_pkg.sv | 14 +
 rtl/regfile_read_port.sv | 41 ++++
 rtl/mips_register_file.sv | 69 ++++++
 tb/tb_mips_register_file.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, register-address and data-word types.
// Reused by the register file, ALU and pipeline stages.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: $0 force, write-first bypass and a stall-gated output register.
// Instantiated once per source operand (rs, rt).
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReadEn,
    input  logic [ADDR_W-1:0] ReadReg,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] StoredData,
    output logic [DATA_W-1:0] ReadData
);

    logic [DATA_W-1:0] sel_data;

    always_comb begin
        // NOTE: default assigned first so every path drives sel_data and no latch is inferred.
        sel_data = StoredData;
        if (ReadReg == ADDR_W'(REG_ZERO)) begin
            sel_data = '0;
        end else if (RegWrite && (WriteReg == ReadReg)) begin
            sel_data = WriteData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: non-blocking assignments for state so all flops sample pre-edge values.
        if (!Reset_n) begin
            ReadData <= '0;
        end else if (ReadEn) begin
            ReadData <= sel_data;
        end
    end

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: one write port, two registered read ports with
// same-edge write bypass; register $0 is hardwired to zero.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              ReadEn,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_en;

    assign write_en = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: the array is reset entry by entry, so it maps to flops rather than a RAM
        // macro; that is what guarantees unwritten registers read 0 instead of X.
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ReadEn     (ReadEn),
        .ReadReg    (ReadReg1),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .StoredData (regs[ReadReg1]),
        .ReadData   (ReadData1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ReadEn     (ReadEn),
        .ReadReg    (ReadReg2),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .StoredData (regs[ReadReg2]),
        .ReadData   (ReadData2)
    );

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed scenarios plus random traffic
// compared against an array-based model of the register file.
module tb_mips_register_file;
    import mips_pkg::*;

    logic      Clk;
    logic      Reset_n;
    logic      RegWrite;
    reg_addr_t WriteReg;
    word_t     WriteData;
    logic      ReadEn;
    reg_addr_t ReadReg1;
    reg_addr_t ReadReg2;
    word_t     ReadData1;
    word_t     ReadData2;

    int n_checks = 0;
    int n_fail   = 0;

    word_t mem [32];
    word_t exp1;
    word_t exp2;

    mips_register_file dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadEn    (ReadEn),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Value a read of address a returns on an edge that also carries the given write.
    function automatic word_t model_read(input reg_addr_t a, input logic we,
                                         input reg_addr_t wa, input word_t wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
    task automatic step(input logic we, input reg_addr_t wa, input word_t wd,
                        input logic re, input reg_addr_t r1, input reg_addr_t r2);
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadEn    = re;
        ReadReg1  = r1;
        ReadReg2  = r2;
        @(posedge Clk);
        if (re) begin
            exp1 = model_read(r1, we, wa, wd);
            exp2 = model_read(r2, we, wa, wd);
        end
        if (we && wa != 0) mem[wa] = wd;
        #1;
    endtask

    task automatic model_clear();
        foreach (mem[i]) mem[i] = '0;
        exp1 = '0;
        exp2 = '0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 32; i++) begin
            step(1'b1, reg_addr_t'(i), $urandom | 32'h1, 1'b0, '0, '0);
        end
        step(1'b0, '0, '0, 1'b1, 5'd5, 5'd6);
        n_checks++;
        if (ReadData1 !== exp1 || ReadData2 !== exp2) begin
            n_fail++;
            $display("FAIL reset_prefill: got %h/%h expected %h/%h", ReadData1, ReadData2, exp1, exp2);
        end
        // Assert reset mid-cycle with a write pending; outputs must clear without an edge.
        #2;
        RegWrite  = 1'b1;
        WriteReg  = 5'd7;
        WriteData = 32'hCAFE_F00D;
        Reset_n   = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%h expected 0/0", ReadData1, ReadData2);
        end
        @(posedge Clk);
        #1;
        n_checks++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_held: got %h/%h expected 0/0", ReadData1, ReadData2);
        end
        @(negedge Clk);
        Reset_n  = 1'b1;
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, '0, '0, 1'b1, reg_addr_t'(i), reg_addr_t'(31 - i));
            n_checks++;
            if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read addr %0d/%0d: got %h/%h expected 0/0",
                         i, 31 - i, ReadData1, ReadData2);
            end
        end
    endtask

    task automatic test_basic_write_read();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
        n_checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_rd1: got %h expected deadbeef", ReadData1);
        end
    endtask

    task automatic test_zero_reg();
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        n_checks++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_bypass: got %h/%h expected 0/0", ReadData1, ReadData2);
        end
        step(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
        n_checks++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_stored: got %h/%h expected 0/0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 5'd9, 32'h0BAD_0BAD, 1'b0, '0, '0);
        step(1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd9);
        n_checks++;
        if (ReadData1 !== 32'h12345678 || ReadData2 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass: got %h/%h expected 12345678/12345678", ReadData1, ReadData2);
        end
    endtask

    task automatic test_stall_hold();
        step(1'b1, 5'd3, 32'hA, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd0, 5'd3);
        n_checks++;
        if (ReadData2 !== 32'hA) begin
            n_fail++;
            $display("FAIL stall_pre: got %h expected a", ReadData2);
        end
        for (int c = 0; c < 3; c++) begin
            step(c == 0, 5'd3, 32'hB, 1'b0, 5'd0, 5'd3);
            n_checks++;
            if (ReadData2 !== 32'hA) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got %h expected a", c, ReadData2);
            end
        end
        step(1'b0, '0, '0, 1'b1, 5'd0, 5'd3);
        n_checks++;
        if (ReadData2 !== 32'hB) begin
            n_fail++;
            $display("FAIL stall_release: got %h expected b", ReadData2);
        end
    endtask

    task automatic test_dual_port();
        step(1'b1, 5'd1, 32'h1, 1'b0, '0, '0);
        step(1'b1, 5'd31, 32'h1F, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd1, 5'd31);
        n_checks++;
        if (ReadData1 !== 32'h1 || ReadData2 !== 32'h1F) begin
            n_fail++;
            $display("FAIL dual_port: got %h/%h expected 1/1f", ReadData1, ReadData2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic      we;
            logic      re;
            reg_addr_t wa;
            reg_addr_t r1;
            reg_addr_t r2;
            // Narrow address range half the time to force bypass and same-address collisions.
            we = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 3) != 0);
            wa = reg_addr_t'(n[0] ? $urandom_range(0, 3) : $urandom_range(0, 31));
            r1 = reg_addr_t'(n[1] ? $urandom_range(0, 3) : $urandom_range(0, 31));
            r2 = reg_addr_t'(n[1] ? $urandom_range(0, 3) : $urandom_range(0, 31));
            step(we, wa, $urandom, re, r1, r2);
            n_checks++;
            if (ReadData1 !== exp1 || ReadData2 !== exp2) begin
                n_fail++;
                $display("FAIL random iter %0d: got %h/%h expected %h/%h",
                         n, ReadData1, ReadData2, exp1, exp2);
            end
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadEn    = 1'b0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        model_clear();
        #12;
        n_checks++;
        if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL power_on_reset: got %h/%h expected 0/0", ReadData1, ReadData2);
        end
        Reset_n = 1'b1;

        test_reset();
        test_basic_write_read();
        test_zero_reg();
        test_bypass();
        test_stall_hold();
        test_dual_port();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
